seg_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Successor to the single-cycle 32-bit combinational adder with signed overflow.
- Generalised in width. Adds a subtract mode, unsigned/signed overflow selection, carry/zero/negative flags and a start/done handshake.
- Processes SEG_W bits per clock, LSB segment first, so wide operands close timing in the CPU ALU/multi-cycle datapath.

---
 rtl/seg_addsub.sv | 129 ++++++++++++
 tb/tb_seg_addsub.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_addsub.sv
// Multi-cycle adder/subtractor: adds SEG_W bits per clock, LSB segment first,
// and reports carry/borrow, selectable signed/unsigned overflow, zero and negative.
module seg_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    seg_cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_next;
    logic             c_r;
    logic             sub_r;
    logic             sign_r;
    logic             a_msb;
    logic             b_msb;
    logic [SEG_W:0]   slice;
    logic             accept;
    logic             last;

    // Handshake: a request is taken (accept) on any edge where start=1 while the
    // block is in IDLE or DONE; start during RUN is ignored. done is a one-cycle
    // pulse with z and the flags valid, which then hold until the next done.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (seg_cnt == CW'(NSEG - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right one segment per cycle; the sum fills in from the top
    // so it is fully aligned once the last segment lands.
    always_comb begin
        slice    = {1'b0, a_r[SEG_W-1:0]} + {1'b0, b_r[SEG_W-1:0]} + {{SEG_W{1'b0}}, c_r};
        sum_next = (sum_r >> SEG_W) | (WIDTH'(slice[SEG_W-1:0]) << (WIDTH - SEG_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_cnt  <= '0;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            c_r      <= 1'b0;
            sub_r    <= 1'b0;
            sign_r   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            z        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Subtraction is a + ~b + 1, with the +1 entering as carry-in.
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                c_r     <= sub;
                sub_r   <= sub;
                sign_r  <= sign;
                a_msb   <= a[WIDTH-1];
                b_msb   <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                sum_r   <= '0;
                seg_cnt <= '0;
                busy    <= 1'b1;
            end else if (state == RUN) begin
                a_r     <= a_r >> SEG_W;
                b_r     <= b_r >> SEG_W;
                c_r     <= slice[SEG_W];
                sum_r   <= sum_next;
                seg_cnt <= seg_cnt + 1'b1;
                if (last) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    z        <= sum_next;
                    carry    <= slice[SEG_W] ^ sub_r;
                    overflow <= sign_r ? ((a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb))
                                       : (slice[SEG_W] ^ sub_r);
                    zero     <= (sum_next == '0);
                    negative <= sum_next[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_addsub.sv
// Self-checking bench for seg_addsub: three configurations (32/8, 32/32, 16/4)
// checked against an arithmetic reference model through per-instance queues.
module tb_seg_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic        sub_in = 1'b0, sign_in = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;

    logic        busy0, done0, carry0, ov0, zero0, neg0;
    logic [31:0] z0;
    logic        busy1, done1, carry1, ov1, zero1, neg1;
    logic [31:0] z1;
    logic        busy2, done2, carry2, ov2, zero2, neg2;
    logic [15:0] z2;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] q2[$];
    logic [35:0] last_exp0 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_addsub #(.WIDTH(32), .SEG_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub_in), .sign(sign_in),
        .a(a_in), .b(b_in), .busy(busy0), .done(done0), .z(z0),
        .carry(carry0), .overflow(ov0), .zero(zero0), .negative(neg0)
    );

    seg_addsub #(.WIDTH(32), .SEG_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub_in), .sign(sign_in),
        .a(a_in), .b(b_in), .busy(busy1), .done(done1), .z(z1),
        .carry(carry1), .overflow(ov1), .zero(zero1), .negative(neg1)
    );

    seg_addsub #(.WIDTH(16), .SEG_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub_in), .sign(sign_in),
        .a(a_in), .b(b_in[15:0]), .busy(busy2), .done(done2), .z(z2),
        .carry(carry2), .overflow(ov2), .zero(zero2), .negative(neg2)
    );

    // Reference: exact integer arithmetic, packed as {z, carry, overflow, zero, negative}.
    function automatic logic [35:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic s, input logic g);
        longint      mask, ua, ub, sa, sb, r_u, r_s, smax, smin;
        logic        c, ovs;
        logic [31:0] zz;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
        r_u  = s ? ua - ub : ua + ub;
        c    = s ? (ua < ub) : (r_u > mask);
        r_s  = s ? sa - sb : sa + sb;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        ovs  = (r_s > smax) || (r_s < smin);
        zz   = 32'(r_u & mask);
        return {zz, c, (g ? ovs : c), (zz == 32'h0), zz[w-1]};
    endfunction

    function automatic logic [35:0] got_of(input int inst);
        case (inst)
            0:       return {z0, carry0, ov0, zero0, neg0};
            1:       return {z1, carry1, ov1, zero1, neg1};
            default: return {16'h0, z2, carry2, ov2, zero2, neg2};
        endcase
    endfunction

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [35:0] pop_exp(input int inst);
        logic [35:0] e;
        e = 'x;
        case (inst)
            0:       if (q0.size() > 0) e = q0.pop_front();
            1:       if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF >> (32 - w);
            2:       return 32'h1 << (w - 1);
            3:       return (32'h1 << (w - 1)) - 1;
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Driver: presents one request for a single edge and records its expectation.
    task automatic issue(input int inst, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, input logic g);
        a_in    = av;
        b_in    = bv;
        sub_in  = s;
        sign_in = g;
        case (inst)
            0:       begin q0.push_back(model(32, av, bv, s, g)); start0 = 1'b1; end
            1:       begin q1.push_back(model(32, av, bv, s, g)); start1 = 1'b1; end
            default: begin q2.push_back(model(16, av, bv, s, g)); start2 = 1'b1; end
        endcase
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges since the accepting edge.
    task automatic wait_done(input int inst, output int lat, output bit ok);
        lat = 0;
        while (!done_of(inst) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = done_of(inst);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_of(i), done_of(i), got_of(i)} !== 38'h0) begin
                errors++;
                $display("FAIL reset inst%0d: got %h, expected 0", i, {busy_of(i), done_of(i), got_of(i)});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_signed_ovf();
        int          lat, busy_cyc;
        logic [35:0] e;
        issue(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        lat      = 0;
        busy_cyc = 0;
        while (!done0 && lat < 40) begin
            if (busy0) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_ovf latency: got %0d, expected 4", lat); end
        checks++;
        if (busy_cyc !== 4) begin errors++; $display("FAIL add_ovf busy cycles: got %0d, expected 4", busy_cyc); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL add_ovf busy at done: got %b, expected 0", busy0); end
        e = pop_exp(0);
        last_exp0 = e;
        checks++;
        if (got0_val() !== e) begin errors++; $display("FAIL add_ovf result: got %h, expected %h", got0_val(), e); end
        checks++;
        if (z0 !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf z: got %h, expected 80000000", z0); end
        @(posedge clk); #1;
        checks++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL add_ovf done pulse width: done still %b", done0); end
    endtask

    function automatic logic [35:0] got0_val();
        return got_of(0);
    endfunction

    task automatic test_add_unsigned();
        int          lat;
        bit          ok;
        logic [35:0] e;
        for (int g = 0; g < 2; g++) begin
            issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0, g[0]);
            wait_done(0, lat, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL add_uns timeout sign=%0d: no done within %0d cycles", g, lat); end
            e = pop_exp(0);
            last_exp0 = e;
            checks++;
            if (got0_val() !== e) begin errors++; $display("FAIL add_uns sign=%0d: got %h, expected %h", g, got0_val(), e); end
        end
        checks++;
        if ({z0, carry0, ov0, zero0} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_uns signed flags: got z=%h c=%b ov=%b zero=%b, expected z=0 c=1 ov=0 zero=1",
                     z0, carry0, ov0, zero0);
        end
    endtask

    task automatic test_sub();
        int          lat;
        bit          ok;
        logic [35:0] e;
        logic [31:0] av[2] = '{32'h5, 32'h8000_0000};
        logic [31:0] bv[2] = '{32'h7, 32'h1};
        for (int i = 0; i < 2; i++) begin
            issue(0, av[i], bv[i], 1'b1, 1'b1);
            wait_done(0, lat, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL sub%0d timeout: no done within %0d cycles", i, lat); end
            e = pop_exp(0);
            last_exp0 = e;
            checks++;
            if (got0_val() !== e) begin errors++; $display("FAIL sub%0d: got %h, expected %h", i, got0_val(), e); end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        bit          ok;
        logic [35:0] e;
        issue(0, 32'd10, 32'd20, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_in   = 32'd99;
        b_in   = 32'd1;
        sub_in = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        checks++;
        if (z0 !== last_exp0[35:4]) begin errors++; $display("FAIL hold mid-op: got %h, expected %h", z0, last_exp0[35:4]); end
        wait_done(0, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ignore_start timeout: no done within %0d cycles", lat); end
        e = pop_exp(0);
        last_exp0 = e;
        checks++;
        if (got0_val() !== e) begin errors++; $display("FAIL ignore_start: got %h, expected %h", got0_val(), e); end
        issue(0, 32'd3, 32'd4, 1'b0, 1'b0);
        checks++;
        if ({busy0, done0} !== 2'b10) begin errors++; $display("FAIL b2b accept: busy,done got %b, expected 10", {busy0, done0}); end
        checks++;
        if (z0 !== 32'd30) begin errors++; $display("FAIL b2b hold: got %h, expected 0000001e", z0); end
        wait_done(0, lat, ok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL b2b latency: got %0d, expected 4", lat); end
        e = pop_exp(0);
        last_exp0 = e;
        checks++;
        if (got0_val() !== e || z0 !== 32'd7) begin errors++; $display("FAIL b2b result: got %h, expected %h", got0_val(), e); end
        @(posedge clk); #1;
        checks++;
        if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL b2b after: busy,done got %b, expected 00", {busy0, done0}); end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        issue(0, 32'h55, 32'h66, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        checks++;
        if ({busy0, done0, got0_val()} !== 38'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h, expected 0", {busy0, done0, got0_val()});
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL reset_mid done pulses: got %0d, expected 0", pulses); end
    endtask

    task automatic test_param_sweep();
        int          lat;
        bit          ok;
        logic [35:0] e;
        issue(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done(1, lat, ok);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL nseg1 latency: got %0d, expected 1", lat); end
        e = pop_exp(1);
        checks++;
        if (got_of(1) !== e || z1 !== 32'h2345_6789) begin errors++; $display("FAIL nseg1: got %h, expected %h", got_of(1), e); end
        issue(2, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        wait_done(2, lat, ok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL w16 latency: got %0d, expected 4", lat); end
        e = pop_exp(2);
        checks++;
        if (got_of(2) !== e || {z2, carry2} !== 17'h1) begin errors++; $display("FAIL w16: got %h, expected %h", got_of(2), e); end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int inst, input int n);
        int          lat, w, nseg;
        bit          ok;
        logic [35:0] e;
        w    = (inst == 2) ? 16 : 32;
        nseg = (inst == 1) ? 1 : 4;
        for (int i = 0; i < n; i++) begin
            issue(inst, pick(w), pick(w), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(inst, lat, ok);
            checks++;
            if (!ok || lat !== nseg) begin
                errors++;
                $display("FAIL random inst%0d #%0d latency: got %0d, expected %0d", inst, i, lat, nseg);
            end
            e = pop_exp(inst);
            checks++;
            if (got_of(inst) !== e) begin
                errors++;
                $display("FAIL random inst%0d #%0d: got %h, expected %h", inst, i, got_of(inst), e);
            end
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_signed_ovf();
        test_add_unsigned();
        test_sub();
        test_back_to_back();
        test_reset_mid_op();
        test_param_sweep();
        test_random(0, 2000);
        test_random(1, 2000);
        test_random(2, 2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
